// File: rtl/mem_arbiter_if.sv
// One split-transaction memory port: req/addr_ok request channel, data_ok/rdata response channel.
// The master drives the request; the slave accepts it and later returns one response.
interface mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic              req;
  logic              write;
  logic [XLEN/8-1:0] wstrb;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [XLEN-1:0]   rdata;

  modport master (output req, write, wstrb, addr, wdata,
                  input  addr_ok, data_ok, rdata);
  modport slave  (input  req, write, wstrb, addr, wdata,
                  output addr_ok, data_ok, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Merges the core's iram and dram ports onto one memory port. A small ID FIFO records the
// order of accepted requests so each in-order response is steered back to its issuer.
module mem_arbiter #(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  iram,
  mem_arbiter_if.slave  dram,
  mem_arbiter_if.master mem,
  output logic          err_unexpected
);
  localparam int          PW       = $clog2(MAX_OUTSTANDING);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(MAX_OUTSTANDING);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t                     r_state;
  logic                       r_locked_id;
  logic                       r_last_grant;
  logic                       r_err;
  logic [MAX_OUTSTANDING-1:0] r_id_fifo;
  logic [PW-1:0]              r_wptr;
  logic [PW-1:0]              r_rptr;
  logic [PW:0]                r_count;

  logic              w_full, w_empty, w_sel, w_req, w_hs, w_pop, w_head;
  logic              w_write;
  logic [XLEN/8-1:0] w_wstrb;
  logic [XLEN-1:0]   w_addr, w_wdata;

  always_comb begin
    w_full  = (r_count == FULL_CNT);
    w_empty = (r_count == '0);
    // Selection is frozen while a presented request waits for the slave.
    if (r_state == S_HOLD)          w_sel = r_locked_id;
    else if (iram.req && dram.req)  w_sel = ~r_last_grant;
    else                            w_sel = dram.req;
    // Full check uses the pre-pop count; a same-cycle response does not free a slot.
    w_req   = !w_full && ((r_state == S_HOLD) || iram.req || dram.req);
    w_hs    = w_req && mem.addr_ok;
    w_write = w_sel ? dram.write : iram.write;
    w_wstrb = w_sel ? dram.wstrb : iram.wstrb;
    w_addr  = w_sel ? dram.addr  : iram.addr;
    w_wdata = w_sel ? dram.wdata : iram.wdata;
    w_head  = r_id_fifo[r_rptr];
    w_pop   = mem.data_ok && !w_empty;
  end

  assign mem.req   = w_req;
  assign mem.write = w_write;
  assign mem.wstrb = w_wstrb;
  assign mem.addr  = w_addr;
  assign mem.wdata = w_wdata;

  assign iram.addr_ok = w_hs && !w_sel;
  assign dram.addr_ok = w_hs &&  w_sel;
  assign iram.data_ok = w_pop && !w_head;
  assign dram.data_ok = w_pop &&  w_head;
  assign iram.rdata   = mem.rdata;
  assign dram.rdata   = mem.rdata;

  assign err_unexpected = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_locked_id  <= 1'b0;
      r_last_grant <= 1'b0;
      r_err        <= 1'b0;
      r_id_fifo    <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
    end else begin
      if (w_hs) begin
        r_id_fifo[r_wptr] <= w_sel;
        r_wptr            <= r_wptr + 1'b1;
        r_last_grant      <= w_sel;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_hs, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (mem.data_ok && w_empty) r_err <= 1'b1;
      case (r_state)
        S_IDLE: if (w_req && !mem.addr_ok) begin
          r_state     <= S_HOLD;
          r_locked_id <= w_sel;
        end
        S_HOLD: if (w_hs) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios followed by random traffic; arbitration checked against a rule model
// each cycle, responses checked by a scoreboard monitor fed with per-master expectations.
module tb_mem_arbiter;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;
  always #5 clk = ~clk;

  mem_arbiter_if #(.XLEN(XLEN)) im();
  mem_arbiter_if #(.XLEN(XLEN)) dm();
  mem_arbiter_if #(.XLEN(XLEN)) mm();

  mem_arbiter #(.XLEN(XLEN), .MAX_OUTSTANDING(DEPTH)) dut (
    .clk(clk), .rst(rst), .iram(im), .dram(dm), .mem(mm), .err_unexpected(err)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  logic [31:0] slv_q[$];
  bit          ord_q[$];
  bit          m_last, m_locked, m_lock_id, m_err;
  bit          hs_i, hs_d;
  logic [31:0] next_rdata = 32'h1234_5678;
  logic [31:0] mon_e;

  task automatic chk1(string name, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every master response must match the oldest expectation for it.
  always @(negedge clk) begin
    if (!rst) begin
      if (im.data_ok) begin
        if (exp_i.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL iram_resp: data_ok asserted, expected none");
        end else begin
          mon_e = exp_i.pop_front();
          chk32("iram_rdata", im.rdata, mon_e);
        end
      end
      if (dm.data_ok) begin
        if (exp_d.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL dram_resp: data_ok asserted, expected none");
        end else begin
          mon_e = exp_d.pop_front();
          chk32("dram_rdata", dm.rdata, mon_e);
        end
      end
    end
  end

  task automatic idle_inputs();
    im.req = 0; im.write = 0; im.wstrb = '0; im.addr = '0; im.wdata = '0;
    dm.req = 0; dm.write = 0; dm.wstrb = '0; dm.addr = '0; dm.wdata = '0;
    mm.addr_ok = 0; mm.data_ok = 0; mm.rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_i.delete(); exp_d.delete(); slv_q.delete(); ord_q.delete();
    m_last = 0; m_locked = 0; m_lock_id = 0; m_err = 0;
  endtask

  task automatic drv(bit d, bit w, logic [31:0] a, logic [31:0] wd, logic [3:0] s);
    if (d) begin dm.req = 1; dm.write = w; dm.addr = a; dm.wdata = wd; dm.wstrb = s; end
    else   begin im.req = 1; im.write = w; im.addr = a; im.wdata = wd; im.wstrb = s; end
  endtask

  task automatic slave_drive(bit aok, bit dok);
    mm.addr_ok = aok;
    mm.data_ok = dok;
    mm.rdata   = (dok && slv_q.size() > 0) ? slv_q[0] : 32'h0BAD_0BAD;
  endtask

  // One clock cycle: compare against the arbitration rules, then advance the model.
  task automatic step();
    bit sel, ereq, hs, id;
    @(negedge clk);
    if (m_locked)                sel = m_lock_id;
    else if (im.req && dm.req)   sel = !m_last;
    else                         sel = dm.req;
    ereq = (ord_q.size() < DEPTH) && (m_locked || im.req || dm.req);
    chk1("mem_req", mm.req, ereq);
    chk1("iram_addr_ok", im.addr_ok, ereq && mm.addr_ok && !sel);
    chk1("dram_addr_ok", dm.addr_ok, ereq && mm.addr_ok && sel);
    chk1("err_unexpected", err, m_err);
    if (ereq) begin
      chk32("mem_addr", mm.addr, sel ? dm.addr : im.addr);
      chk32("mem_wdata", mm.wdata, sel ? dm.wdata : im.wdata);
      chk32("mem_ctl", 32'({mm.write, mm.wstrb}),
            sel ? 32'({dm.write, dm.wstrb}) : 32'({im.write, im.wstrb}));
    end
    if (mm.data_ok) begin
      if (ord_q.size() > 0) begin
        id = ord_q.pop_front();
        void'(slv_q.pop_front());
        chk1("route_iram", im.data_ok, !id);
        chk1("route_dram", dm.data_ok, id);
      end else begin
        chk1("stray_data_ok", im.data_ok | dm.data_ok, 1'b0);
        m_err = 1;
      end
    end else begin
      chk1("data_ok_idle", im.data_ok | dm.data_ok, 1'b0);
    end
    hs = ereq && mm.addr_ok;
    hs_i = hs && !sel;
    hs_d = hs && sel;
    if (hs) begin
      slv_q.push_back(next_rdata);
      ord_q.push_back(sel);
      if (sel) exp_d.push_back(next_rdata); else exp_i.push_back(next_rdata);
      next_rdata = $urandom;
      m_last = sel;
      m_locked = 0;
    end else if (ereq) begin
      m_locked = 1;
      m_lock_id = sel;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    im.req = 0; dm.req = 0;
    for (int k = 0; k < 16 && slv_q.size() > 0; k++) begin
      slave_drive(0, 1);
      step();
    end
    slave_drive(0, 0);
  endtask

  initial begin
    bit pend_i, pend_d;
    int gi, gd;

    // Reset state with idle masters
    do_reset();
    #2 chk1("reset_err", err, 1'b0);
    chk1("reset_mem_req", mm.req, 1'b0);
    step();

    // Single-master pass-through
    drv(0, 0, 32'h100, 32'h0, 4'h0);
    slave_drive(1, 0);
    next_rdata = 32'hDEAD_BEEF;
    #2 chk1("t1_iram_addr_ok", im.addr_ok, 1'b1);
    step();
    im.req = 0; slave_drive(0, 0);
    step();
    slave_drive(0, 1);
    #2 chk1("t1_iram_data_ok", im.data_ok, 1'b1);
    chk32("t1_iram_rdata", im.rdata, 32'hDEAD_BEEF);
    chk1("t1_dram_data_ok", dm.data_ok, 1'b0);
    step();
    slave_drive(0, 0);
    step();

    // Contention: grants after reset alternate D, I, D, I
    do_reset();
    gi = 0; gd = 0;
    for (int k = 0; k < 4; k++) begin
      drv(0, 0, 32'h1000 + gi, 32'h0, 4'h0);
      drv(1, 1, 32'h2000 + gd, 32'hA5A5_0000 + gd, 4'hF);
      slave_drive(1, 0);
      #2 chk1("t2_rr_grant_dram", dm.addr_ok, (k % 2) == 0);
      step();
      if (hs_i) gi++;
      if (hs_d) gd++;
    end
    im.req = 0; dm.req = 0;
    for (int k = 0; k < 4; k++) begin
      slave_drive(0, 1);
      #2 chk1("t2_resp_dram", dm.data_ok, (k % 2) == 0);
      step();
    end
    slave_drive(0, 0);

    // HOLD lock: iram presented and stalled while dram competes
    drv(0, 0, 32'h300, 32'h0, 4'h0);
    slave_drive(0, 0);
    #2 chk32("t3_addr_c0", mm.addr, 32'h300);
    step();
    for (int k = 1; k < 3; k++) begin
      drv(1, 0, 32'h400, 32'h0, 4'h0);
      #2 chk32("t3_addr_held", mm.addr, 32'h300);
      chk1("t3_dram_blocked", dm.addr_ok, 1'b0);
      step();
    end
    slave_drive(1, 0);
    #2 chk1("t3_iram_hs", im.addr_ok, 1'b1);
    step();
    im.req = 0;
    #2 chk1("t3_dram_next", dm.addr_ok, 1'b1);
    step();
    drain();

    // FIFO full: four reads outstanding block the fifth
    for (int k = 0; k < 4; k++) begin
      drv(1, 0, 32'h500 + k, 32'h0, 4'h0);
      slave_drive(1, 0);
      step();
    end
    drv(1, 0, 32'h504, 32'h0, 4'h0);
    #2 chk1("t4_full_mem_req", mm.req, 1'b0);
    chk1("t4_full_addr_ok", dm.addr_ok, 1'b0);
    step();
    slave_drive(1, 1);
    #2 chk1("t4_full_pop_same_cycle", mm.req, 1'b0);
    step();
    slave_drive(1, 0);
    #2 chk1("t4_fifth_accepted", dm.addr_ok, 1'b1);
    step();
    dm.req = 0;

    // Push and pop together at count 3, across pointer wrap
    slave_drive(0, 1);
    step();
    drv(0, 1, 32'h600, 32'hCAFE_0001, 4'h3);
    slave_drive(1, 1);
    #2 chk1("t5_pushpop_hs", im.addr_ok, 1'b1);
    step();
    im.req = 0;
    drv(1, 0, 32'h700, 32'h0, 4'h0);
    slave_drive(1, 0);
    #2 chk1("t5_push_to_4", dm.addr_ok, 1'b1);
    step();
    dm.req = 0;
    drv(0, 0, 32'h601, 32'h0, 4'h0);
    #2 chk1("t5_full_after_pushpop", mm.req, 1'b0);
    step();
    slave_drive(1, 1);
    step();
    slave_drive(1, 1);
    #2 chk1("t5_accept_after_pop", im.addr_ok, 1'b1);
    step();
    drain();

    // Unexpected response, sticky flag, cleared by reset
    slave_drive(0, 1);
    #2 chk1("t6_no_data_ok", im.data_ok | dm.data_ok, 1'b0);
    step();
    slave_drive(0, 0);
    #2 chk1("t6_err_set", err, 1'b1);
    step();
    step();
    do_reset();
    #2 chk1("t6_err_cleared", err, 1'b0);
    step();

    // Random traffic
    pend_i = 0; pend_d = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!pend_i) begin
        im.req = 0;
        if ($urandom_range(2) == 0) begin
          drv(0, 1'($urandom), $urandom, $urandom, 4'($urandom));
          pend_i = 1;
        end
      end
      if (!pend_d) begin
        dm.req = 0;
        if ($urandom_range(2) == 0) begin
          drv(1, 1'($urandom), $urandom, $urandom, 4'($urandom));
          pend_d = 1;
        end
      end
      slave_drive($urandom_range(3) != 0, (slv_q.size() > 0) && ($urandom_range(1) == 1));
      step();
      if (hs_i) pend_i = 0;
      if (hs_d) pend_d = 0;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master to one-slave arbiter that sits directly below the CPU core. It merges the core's instruction-RAM port and data-RAM port onto a single shared memory port, so the core can run against one unified memory. All three ports use the same split-transaction req/addr_ok/data_ok protocol. The block tracks the ordering of outstanding requests so that every data_ok is routed back to the master that issued it.

## Interface
Parameters:
- XLEN, 32, data/address width
- MAX_OUTSTANDING, 4, depth of the in-flight ID FIFO; power of 2, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- iram_req / iram_write  in  1 / 1  instruction master request, write flag
- iram_wstrb  in  XLEN/8  instruction master byte strobes
- iram_addr / iram_wdata  in  XLEN / XLEN  instruction master address, write data
- iram_addr_ok / iram_data_ok  out  1 / 1  request accepted / response valid, instruction master
- iram_rdata  out  XLEN  read data, instruction master
- dram_*  same set as iram_*, for the data master
- mem_req / mem_write  out  1 / 1  slave request, write flag
- mem_wstrb  out  XLEN/8  slave byte strobes
- mem_addr / mem_wdata  out  XLEN / XLEN  slave address, write data
- mem_addr_ok / mem_data_ok  in  1 / 1  slave accept / slave response
- mem_rdata  in  XLEN  slave read data
- err_unexpected  out  1  sticky flag: mem_data_ok seen with no outstanding request

## Operation
Protocol rules, all ports:
- A handshake occurs when req && addr_ok.
- Once a master raises req, its request fields stay stable until its handshake.
- Writes also receive exactly one data_ok.
- Responses return in request order.
- Masters always accept data_ok; there is no response backpressure.

Arbitration state machine:
- **IDLE**, no lock.
  - One master requesting: select it.
  - Both requesting: round-robin against last_grant. The master not granted last wins.
  - If the FIFO is not full, drive mem_req=1 with the selected master's fields, muxed combinationally.
  - If mem_addr_ok=1 in the same cycle, complete the handshake and stay in IDLE.
  - If mem_addr_ok=0, go to **HOLD** and latch locked_id.
- **HOLD**:
  - Selection is frozen to locked_id regardless of the other master.
  - mem_req stays 1 until mem_addr_ok, then return to IDLE.
  - The selected master may not drop req; this is a protocol rule and the block does not check it.
- FIFO full (count == MAX_OUTSTANDING): mem_req=0 and both addr_ok=0.
  - The full check uses the count before any same-cycle pop. This is conservative by design.
  - In HOLD with the FIFO full, mem_req drops. This cannot occur, because HOLD is entered only when the FIFO is not full and no push happens while in HOLD.

On a handshake:
- Only the selected master's addr_ok = mem_addr_ok; the other master's addr_ok = 0.
- Push the selected master's ID (0 = iram, 1 = dram) into the FIFO.
- Update last_grant.

Response routing:
- On mem_data_ok with the FIFO not empty: pop the head entry and assert data_ok to the master named by the head entry.
- iram_rdata = dram_rdata = mem_rdata at all times.
- mem_data_ok with the FIFO empty: no data_ok is issued and err_unexpected is set. It stays set until rst.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo MAX_OUTSTANDING.

## Timing
- Request path is combinational: master req to mem_req, and mem_addr_ok to master addr_ok, in the same cycle.
- Response path is combinational: mem_data_ok to the master's data_ok, in the same cycle, with zero added latency.
- A FIFO push is visible to a pop from the next cycle onward. The slave must not return data_ok in the same cycle as the addr_ok of that same request.
- Throughput: one handshake per cycle while the FIFO is not full.
- Reset values:
  - state IDLE, count 0, read/write pointers 0
  - last_grant = iram, so the first contested grant goes to dram
  - err_unexpected 0
  - with masters idle: mem_req 0, all addr_ok/data_ok 0
- Reset mid-transaction: the FIFO is cleared and in-flight responses are forgotten. Any later mem_data_ok sets err_unexpected. The system must reset the slave together with this block.

## Test plan
- **Single-master pass-through:** iram read at addr 0x100; slave answers addr_ok immediately and data_ok 2 cycles later with 0xDEADBEEF → iram_data_ok one cycle, iram_rdata=0xDEADBEEF, dram_data_ok stays 0.
- **Contention, round-robin:** both masters request every cycle, slave always ready → grants after reset alternate D, I, D, I. Responses returned in order route correctly: 4 responses, data_ok pattern D, I, D, I.
- **HOLD lock:** iram requests, slave holds mem_addr_ok=0 for 3 cycles, dram requests from cycle 1 → mem_addr stays iram's for all 3 cycles, dram_addr_ok=0, dram is granted in the cycle after the iram handshake.
- **FIFO full:** MAX_OUTSTANDING=4, issue 4 dram reads with no data_ok → 5th request sees mem_req=0, addr_ok=0. Return one data_ok → the 5th request is accepted the following cycle.
- **Simultaneous push/pop at count 3:** new handshake plus mem_data_ok in the same cycle → count stays 3 and the correct IDs pop across the pointer wrap.
- **Unexpected response and reset:** mem_data_ok with an empty FIFO → no master data_ok, err_unexpected=1 and held. Assert rst for 1 cycle → err_unexpected=0, count=0.
